// File: rtl/mcp2515_pkg.sv
// Shared MCP2515 instruction set, register constants and sequencer state types.
package mcp2515_pkg;

  localparam logic [7:0] CMD_RESET       = 8'hC0;
  localparam logic [7:0] CMD_WRITE       = 8'h02;
  localparam logic [7:0] CMD_READ_STATUS = 8'hA0;
  localparam logic [7:0] CMD_LOAD_TXB0   = 8'h40;
  localparam logic [7:0] CMD_RTS_TXB0    = 8'h81;
  localparam logic [7:0] REG_CANCTRL     = 8'h0F;
  localparam logic [7:0] MODE_NORMAL     = 8'h00;

  typedef enum logic [3:0] {
    StRstCmd,
    StRstWait,
    StInitMode,
    StIdle,
    StLoad,
    StRts,
    StPoll,
    StPollGap,
    StFinish,
    StError
  } seq_state_e;

  typedef enum logic [1:0] {
    FrIdle,
    FrSetup,
    FrWait,
    FrNext
  } framer_state_e;

  // Byte idx of the LOAD TX BUFFER stream: instruction, SIDH, SIDL, EID8, EID0, DLC, data.
  function automatic logic [7:0] load_byte(input logic [3:0]  idx,
                                           input logic [10:0] id,
                                           input logic [3:0]  dlc,
                                           input logic [63:0] data);
    logic [63:0] shifted;
    shifted = data << {idx - 4'd6, 3'b000};
    case (idx)
      4'd0:       load_byte = CMD_LOAD_TXB0;
      4'd1:       load_byte = id[10:3];
      4'd2:       load_byte = {id[2:0], 5'b00000};
      4'd3, 4'd4: load_byte = 8'h00;
      4'd5:       load_byte = {4'h0, dlc};
      default:    load_byte = shifted[63:56];
    endcase
  endfunction

endpackage

// File: rtl/spi_cmd_framer.sv
// Frames command bytes onto SPI_Master: owns chip select, setup/gap timing,
// the start pulse and done-edge detection.
module spi_cmd_framer
  import mcp2515_pkg::*;
#(
  parameter int unsigned CS_GAP_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_i,
  input  logic [7:0] byte_i,
  input  logic       last_i,
  output logic       byte_done_o,
  output logic [7:0] rx_byte_o,
  output logic       spi_start_o,
  output logic [7:0] spi_data_in_o,
  input  logic       spi_done_i,
  input  logic [7:0] spi_data_out_i,
  output logic       can_cs_n_o
);

  localparam int unsigned   GapW    = $clog2(CS_GAP_CYCLES + 1);
  localparam logic [GapW-1:0] GapLast = GapW'(CS_GAP_CYCLES - 1);
  localparam logic [GapW-1:0] GapOne  = GapW'(1);

  framer_state_e   st_q, st_d;
  logic [GapW-1:0] cnt_q, cnt_d;
  logic            cs_n_q, cs_n_d;
  logic            start_q, start_d;
  logic [7:0]      data_q, data_d;
  logic            done_q;
  logic            done_edge;

  assign done_edge     = spi_done_i & ~done_q;
  assign rx_byte_o     = spi_data_out_i;
  assign spi_start_o   = start_q;
  assign spi_data_in_o = data_q;
  assign can_cs_n_o    = cs_n_q;

  always_comb begin
    st_d        = st_q;
    cnt_d       = cnt_q;
    cs_n_d      = cs_n_q;
    start_d     = 1'b0;
    data_d      = data_q;
    byte_done_o = 1'b0;
    unique case (st_q)
      // cnt counts CS-high cycles; saturates once the gap is satisfied
      FrIdle: begin
        if (cnt_q != GapLast) begin
          cnt_d = cnt_q + GapOne;
        end else if (req_i) begin
          cs_n_d = 1'b0;
          cnt_d  = '0;
          st_d   = FrSetup;
        end
      end
      FrSetup: begin
        if (cnt_q == GapLast) begin
          start_d = 1'b1;
          data_d  = byte_i;
          st_d    = FrWait;
        end else begin
          cnt_d = cnt_q + GapOne;
        end
      end
      FrWait: begin
        if (done_edge) begin
          byte_done_o = 1'b1;
          if (last_i) begin
            cs_n_d = 1'b1;
            cnt_d  = '0;
            st_d   = FrIdle;
          end else begin
            st_d = FrNext;
          end
        end
      end
      FrNext: begin
        if (req_i) begin
          start_d = 1'b1;
          data_d  = byte_i;
          st_d    = FrWait;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q    <= FrIdle;
      cnt_q   <= GapLast;
      cs_n_q  <= 1'b1;
      start_q <= 1'b0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      cs_n_q  <= cs_n_d;
      start_q <= start_d;
      data_q  <= data_d;
      done_q  <= spi_done_i;
    end
  end

endmodule

// File: rtl/mcp2515_tx_sequencer.sv
// MCP2515 command sequencer: initialises the controller, then loads TXB0,
// requests transmission and polls status for each CAN frame request.
module mcp2515_tx_sequencer
  import mcp2515_pkg::*;
#(
  parameter int unsigned RST_WAIT_CYCLES = 5000,
  parameter int unsigned CS_GAP_CYCLES   = 4,
  parameter int unsigned POLL_LIMIT      = 1024
) (
  input  logic        clk_50MHz,
  input  logic        reset,
  input  logic        tx_req,
  input  logic [10:0] tx_id,
  input  logic [3:0]  tx_dlc,
  input  logic [63:0] tx_data,
  output logic        tx_ready,
  output logic        tx_done,
  output logic        tx_err,
  output logic        init_done,
  output logic        spi_start,
  output logic [7:0]  spi_data_in,
  input  logic        spi_done,
  input  logic [7:0]  spi_data_out,
  output logic        can_cs_n
);

  localparam int unsigned      RstW     = $clog2(RST_WAIT_CYCLES + 1);
  localparam int unsigned      PollW    = $clog2(POLL_LIMIT + 1);
  localparam logic [RstW-1:0]  RstLast  = RstW'(RST_WAIT_CYCLES - 1);
  localparam logic [RstW-1:0]  RstOne   = RstW'(1);
  localparam logic [PollW-1:0] PollLast = PollW'(POLL_LIMIT - 1);
  localparam logic [PollW-1:0] PollOne  = PollW'(1);

  seq_state_e       state_q, state_d, cmd_next;
  logic [3:0]       idx_q, idx_d;
  logic [RstW-1:0]  rst_cnt_q, rst_cnt_d;
  logic [PollW-1:0] poll_cnt_q, poll_cnt_d;
  logic             init_done_q, init_done_d;
  logic [10:0]      id_q, id_d;
  logic [3:0]       dlc_q, dlc_d;
  logic [63:0]      data_q, data_d;
  logic [3:0]       n_data;

  logic             fr_req, fr_last, fr_byte_done;
  logic [7:0]       fr_byte, fr_rx_byte;

  assign n_data    = (dlc_q > 4'd8) ? 4'd8 : dlc_q;
  assign tx_ready  = (state_q == StIdle);
  assign tx_done   = (state_q == StFinish);
  assign tx_err    = (state_q == StError);
  assign init_done = init_done_q;

  always_comb begin
    state_d     = state_q;
    cmd_next    = state_q;
    idx_d       = idx_q;
    rst_cnt_d   = rst_cnt_q;
    poll_cnt_d  = poll_cnt_q;
    init_done_d = init_done_q;
    id_d        = id_q;
    dlc_d       = dlc_q;
    data_d      = data_q;
    fr_req      = 1'b0;
    fr_byte     = 8'h00;
    fr_last     = 1'b0;
    unique case (state_q)
      StRstCmd: begin
        fr_req    = 1'b1;
        fr_byte   = CMD_RESET;
        fr_last   = 1'b1;
        rst_cnt_d = '0;
        cmd_next  = StRstWait;
      end
      StRstWait: begin
        if (rst_cnt_q == RstLast) begin
          state_d = StInitMode;
        end else begin
          rst_cnt_d = rst_cnt_q + RstOne;
        end
      end
      StInitMode: begin
        fr_req   = 1'b1;
        fr_last  = (idx_q == 4'd2);
        cmd_next = StIdle;
        case (idx_q)
          4'd0:    fr_byte = CMD_WRITE;
          4'd1:    fr_byte = REG_CANCTRL;
          default: fr_byte = MODE_NORMAL;
        endcase
        if (fr_byte_done && fr_last) init_done_d = 1'b1;
      end
      StIdle: begin
        if (tx_req) begin
          id_d       = tx_id;
          dlc_d      = tx_dlc;
          data_d     = tx_data;
          poll_cnt_d = '0;
          idx_d      = '0;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        fr_req   = 1'b1;
        fr_byte  = load_byte(idx_q, id_q, dlc_q, data_q);
        fr_last  = (idx_q == 4'd5 + n_data);
        cmd_next = StRts;
      end
      StRts: begin
        fr_req   = 1'b1;
        fr_byte  = CMD_RTS_TXB0;
        fr_last  = 1'b1;
        cmd_next = StPoll;
      end
      StPoll: begin
        fr_req  = 1'b1;
        fr_byte = (idx_q == 4'd0) ? CMD_READ_STATUS : 8'h00;
        fr_last = (idx_q == 4'd1);
        // status[2] mirrors TXB0CTRL.TXREQ
        if (!fr_rx_byte[2]) begin
          cmd_next = StFinish;
        end else if (poll_cnt_q == PollLast) begin
          cmd_next = StError;
        end else begin
          cmd_next = StPollGap;
        end
        if (fr_byte_done && fr_last) poll_cnt_d = poll_cnt_q + PollOne;
      end
      StPollGap: state_d = StPoll;
      StFinish:  state_d = StIdle;
      StError:   state_d = StIdle;
      default:   state_d = StRstCmd;
    endcase

    if (fr_req && fr_byte_done) begin
      if (fr_last) begin
        idx_d   = '0;
        state_d = cmd_next;
      end else begin
        idx_d = idx_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state_q     <= StRstCmd;
      idx_q       <= '0;
      rst_cnt_q   <= '0;
      poll_cnt_q  <= '0;
      init_done_q <= 1'b0;
      id_q        <= '0;
      dlc_q       <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rst_cnt_q   <= rst_cnt_d;
      poll_cnt_q  <= poll_cnt_d;
      init_done_q <= init_done_d;
      id_q        <= id_d;
      dlc_q       <= dlc_d;
      data_q      <= data_d;
    end
  end

  spi_cmd_framer #(
    .CS_GAP_CYCLES (CS_GAP_CYCLES)
  ) u_framer (
    .clk_i          (clk_50MHz),
    .rst_i          (reset),
    .req_i          (fr_req),
    .byte_i         (fr_byte),
    .last_i         (fr_last),
    .byte_done_o    (fr_byte_done),
    .rx_byte_o      (fr_rx_byte),
    .spi_start_o    (spi_start),
    .spi_data_in_o  (spi_data_in),
    .spi_done_i     (spi_done),
    .spi_data_out_i (spi_data_out),
    .can_cs_n_o     (can_cs_n)
  );

endmodule
